pc_branch_ctrl: RTL and testbench
=================================

# pc_branch_ctrl

Program-counter and branch controller for the 8-bit custom CPU; sits upstream of the ALU, producing the fetch address that drives instruction-memory reads and therefore the ALU command stream. It latches the ALU status flags (zero, parity) from one instruction and uses them to resolve conditional branches in later instructions. Branch targets come from a small programmable lookup table indexed by a 4-bit immediate. It also runs the start/done handshake with the test harness.

## Interface
- PC_W, 10, program-counter width in bits
- LUT_DEPTH, 16, number of branch-target entries (index width is 4 bits; the depth is fixed at 16)
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  harness start request, level-sensitive
- halt_i  input  1  decoded halt instruction, valid in RUN
- branch_cond  input  3  000 never, 001 always, 010 zero, 011 not-zero, 100 parity odd, 101 parity even, 110/111 never
- lut_idx  input  4  branch-target LUT read index
- zero_i  input  1  ALU zero flag
- pari_i  input  1  ALU parity flag
- flag_we  input  1  latch zero_i/pari_i this cycle
- lut_we  input  1  LUT write enable
- lut_waddr  input  4  LUT write index
- lut_wdata  input  PC_W  LUT write data
- pc_o  output  PC_W  registered program counter
- running_o  output  1  high in RUN
- done_o  output  1  high in HALT

## Operation
- FSM states: IDLE, RUN, HALT.
  - IDLE → RUN when start is low.
  - IDLE stays in IDLE while start is high.
  - RUN → HALT on halt_i.
  - RUN → IDLE on start.
  - HALT → IDLE on start.
  - HALT stays in HALT while start is low.
- IDLE:
  - pc_o = 0, zero_q = 0, pari_q = 0.
  - All outputs low except pc_o (which is 0).
- RUN, per rising edge, in priority order:
  1. start high: go to IDLE; pc_o ← 0; flags cleared.
  2. halt_i high: go to HALT; pc_o holds.
  3. Branch taken: pc_o ← LUT[lut_idx].
  4. Otherwise: pc_o ← pc_o + 1, modulo 2^PC_W (all-ones wraps to 0).
- Branch taken means the decode of branch_cond is true, evaluated against the registered flags zero_q and pari_q, never against zero_i/pari_i directly.
  - Parity odd means pari_q = 1.
- Flag registers:
  - zero_q ← zero_i and pari_q ← pari_i on edges where flag_we = 1 and the state is RUN.
  - Flags hold at all other times.
  - When flag_we and a conditional branch occur in the same cycle, the branch uses the old flag values.
- HALT: pc_o and the flags hold; done_o = 1.
- LUT:
  - LUT_DEPTH × PC_W register array.
  - Written on a rising edge when lut_we = 1, in any state.
  - Read combinationally.
  - If a write and a branch hit the same index in the same cycle, the branch uses the pre-write value.
- Reset (asynchronous, any state including mid-run):
  - state ← IDLE.
  - pc_o, zero_q, pari_q, running_o, done_o ← 0.
  - All LUT entries ← 0.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- pc_o update latency: 1 cycle. Instruction fetched at pc N during cycle t; next pc is visible after edge t+1.
- First RUN pc is 0:
  - start falls at edge e; RUN is entered at edge e.
  - pc_o = 0 is held through the first RUN cycle.
  - The first increment happens at edge e+1.
- done_o rises on the edge that samples halt_i; pc_o keeps the halting instruction's address.
- running_o and done_o are never high together.
- A flag written at edge t is usable by a branch sampled at edge t+1 or later.
- rst_n assertion clears outputs immediately, without waiting for a clock edge. Deassertion is synchronised externally.

## Test plan
- Reset mid-run:
  - Stimulus: at pc_o = 37, pull rst_n low between clock edges.
  - Required: pc_o = 0, done_o = 0, running_o = 0 immediately, without waiting for an edge.
  - Required after release: LUT[3] reads 0 (a branch on index 3 goes to 0).
- Sequential run and halt:
  - Stimulus: pulse start, then 5 plain cycles.
  - Required: pc_o steps 0,1,2,3,4,5.
  - Stimulus: halt_i at pc 5.
  - Required: done_o = 1 next cycle, pc_o stays 5, running_o = 0.
- Conditional branch on the old flag:
  - Setup: LUT[2] = 200; zero_q = 0.
  - Stimulus: in the same cycle, flag_we = 1 with zero_i = 1, and branch_cond = 010 with lut_idx = 2.
  - Required: not taken, pc_o increments.
  - Stimulus: next cycle, the same branch.
  - Required: pc_o = 200.
- Parity branches:
  - Setup: pari_q = 1.
  - Stimulus: branch_cond = 100, LUT[7] = 512.
  - Required: pc_o = 512.
  - Stimulus: branch_cond = 101, 110, or 111.
  - Required: pc_o increments each time (not taken).
- Wrap and LUT collision:
  - Stimulus: run to pc = 1023, one plain cycle.
  - Required: pc_o = 0.
  - Stimulus: write LUT[4] = 9 while taking an always branch (001) on idx 4, whose old value is 50.
  - Required: pc_o = 50.
- Restart:
  - Stimulus: assert start during RUN at pc 12.
  - Required: IDLE next edge, pc_o = 0, flags cleared.
  - Stimulus: from HALT, assert start.
  - Required: done_o falls next edge.

Source files
------------

// File: rtl/pc_branch_ctrl.sv
// Program-counter and branch controller for the 8-bit CPU.
// Produces the fetch address and latches the ALU zero/parity flags.
// Conditional branches resolve against the latched flags and jump to
// targets held in a small writable lookup table.
//
// Handshake: the harness holds start high to park the core in IDLE.
// RUN begins on the first edge that samples start low. done_o marks
// HALT, and start brings the core back to IDLE from RUN or HALT.
module pc_branch_ctrl #(
  parameter int PC_W      = 10,
  parameter int LUT_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            halt_i,
  input  logic [2:0]      branch_cond,
  input  logic [3:0]      lut_idx,
  input  logic            zero_i,
  input  logic            pari_i,
  input  logic            flag_we,
  input  logic            lut_we,
  input  logic [3:0]      lut_waddr,
  input  logic [PC_W-1:0] lut_wdata,
  output logic [PC_W-1:0] pc_o,
  output logic            running_o,
  output logic            done_o,
  output logic [1:0]      state_dbg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  logic [1:0]      state_q;
  logic [1:0]      state_d;
  logic [PC_W-1:0] pc_d;
  logic            zero_q;
  logic            pari_q;
  logic            taken;
  logic [PC_W-1:0] lut_q [LUT_DEPTH];

  assign state_dbg = state_q;

  // Next-state decode for the IDLE/RUN/HALT controller.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!start) state_d = S_RUN;
      S_RUN: begin
        if (start)       state_d = S_IDLE;
        else if (halt_i) state_d = S_HALT;
      end
      S_HALT:  if (start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Branch condition decode, always against the latched flags.
  always_comb begin
    taken = 1'b0;
    case (branch_cond)
      3'b001:  taken = 1'b1;
      3'b010:  taken = zero_q;
      3'b011:  taken = ~zero_q;
      3'b100:  taken = pari_q;
      3'b101:  taken = ~pari_q;
      default: taken = 1'b0;
    endcase
  end

  // Next PC: restart clears, halt holds, taken branch jumps, else step.
  always_comb begin
    pc_d = pc_o;
    case (state_q)
      S_IDLE: pc_d = '0;
      S_RUN: begin
        if (start)       pc_d = '0;
        else if (halt_i) pc_d = pc_o;
        else if (taken)  pc_d = lut_q[lut_idx];
        else             pc_d = pc_o + PC_ONE;
      end
      S_HALT: pc_d = start ? '0 : pc_o;
      default: pc_d = '0;
    endcase
  end

  // State, PC and status outputs; status bits follow the next state so they are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_o      <= '0;
      running_o <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_o      <= pc_d;
      running_o <= (state_d == S_RUN);
      done_o    <= (state_d == S_HALT);
    end
  end

  // Flags are cleared on entry to IDLE and captured only while running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      pari_q <= 1'b0;
    end else if (state_d == S_IDLE) begin
      zero_q <= 1'b0;
      pari_q <= 1'b0;
    end else if (state_q == S_RUN && flag_we) begin
      zero_q <= zero_i;
      pari_q <= pari_i;
    end
  end

  // Branch-target table; a same-cycle read sees the pre-write value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LUT_DEPTH; i++) lut_q[i] <= '0;
    end else if (lut_we) begin
      lut_q[lut_waddr] <= lut_wdata;
    end
  end

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Testbench for pc_branch_ctrl: directed vector table, hand-written
// corner sequences, then random traffic against a behavioural model.
module tb_pc_branch_ctrl;

  localparam int PC_W = 10;
  localparam int PC_MOD = 1 << PC_W;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            halt_i;
  logic [2:0]      branch_cond;
  logic [3:0]      lut_idx;
  logic            zero_i;
  logic            pari_i;
  logic            flag_we;
  logic            lut_we;
  logic [3:0]      lut_waddr;
  logic [PC_W-1:0] lut_wdata;
  logic [PC_W-1:0] pc_o;
  logic            running_o;
  logic            done_o;
  logic [1:0]      state_dbg;

  int total = 0;
  int bad   = 0;

  pc_branch_ctrl #(.PC_W(PC_W), .LUT_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_i(halt_i),
    .branch_cond(branch_cond), .lut_idx(lut_idx), .zero_i(zero_i),
    .pari_i(pari_i), .flag_we(flag_we), .lut_we(lut_we),
    .lut_waddr(lut_waddr), .lut_wdata(lut_wdata), .pc_o(pc_o),
    .running_o(running_o), .done_o(done_o), .state_dbg(state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // mode: "idle", "run", "halt"
  string m_mode;
  int    m_pc;
  bit    m_zero;
  bit    m_par;
  int    m_lut [16];

  function automatic void model_reset();
    m_mode = "idle";
    m_pc   = 0;
    m_zero = 0;
    m_par  = 0;
    foreach (m_lut[i]) m_lut[i] = 0;
  endfunction

  // One clock edge of the model, using the inputs sampled at that edge.
  function automatic void model_step();
    bit go;
    int target;
    go = (branch_cond == 3'd1) ||
         (branch_cond == 3'd2 && m_zero) || (branch_cond == 3'd3 && !m_zero) ||
         (branch_cond == 3'd4 && m_par)  || (branch_cond == 3'd5 && !m_par);
    target = m_lut[lut_idx];
    if (m_mode == "idle") begin
      m_pc = 0;
      if (!start) m_mode = "run";
    end else if (m_mode == "run") begin
      if (start) begin
        m_mode = "idle"; m_pc = 0; m_zero = 0; m_par = 0;
      end else begin
        if (halt_i)  m_mode = "halt";
        else if (go) m_pc = target;
        else         m_pc = (m_pc + 1) % PC_MOD;
        if (flag_we) begin m_zero = zero_i; m_par = pari_i; end
      end
    end else begin
      if (start) begin
        m_mode = "idle"; m_pc = 0; m_zero = 0; m_par = 0;
      end
    end
    if (lut_we) m_lut[lut_waddr] = int'(lut_wdata);
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic set_in(input bit st, input bit ht, input bit [2:0] cond,
                        input bit [3:0] idx, input bit zi, input bit pi,
                        input bit fwe, input bit lwe, input bit [3:0] wa,
                        input int wd);
    start = st; halt_i = ht; branch_cond = cond; lut_idx = idx;
    zero_i = zi; pari_i = pi; flag_we = fwe; lut_we = lwe;
    lut_waddr = wa; lut_wdata = PC_W'(wd);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic chk_out(input string name, input int e_pc, input int e_run, input int e_dn);
    chk({name, ".pc"}, int'(pc_o), e_pc);
    chk({name, ".running"}, int'(running_o), e_run);
    chk({name, ".done"}, int'(done_o), e_dn);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit st; bit ht; bit [2:0] cond; bit [3:0] idx;
    bit zi; bit pi; bit fwe; bit lwe; bit [3:0] wa; int wd;
    int pc; bit run; bit dn;
  } vec_t;

  vec_t tbl [28];

  function automatic vec_t mk(bit st, bit ht, bit [2:0] cond, bit [3:0] idx,
                              bit zi, bit pi, bit fwe, bit lwe, bit [3:0] wa,
                              int wd, int pc, bit run, bit dn);
    vec_t v;
    v.st = st; v.ht = ht; v.cond = cond; v.idx = idx; v.zi = zi; v.pi = pi;
    v.fwe = fwe; v.lwe = lwe; v.wa = wa; v.wd = wd; v.pc = pc; v.run = run; v.dn = dn;
    return v;
  endfunction

  initial begin
    // st ht cond  idx zi pi fwe lwe wa wd   pc   run dn
    tbl[0]  = mk(1, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0,   0,   0, 0);
    tbl[1]  = mk(1, 0, 3'd0, 0, 0, 0, 0, 1, 2, 200, 0,   0, 0);
    tbl[2]  = mk(1, 0, 3'd0, 0, 0, 0, 0, 1, 7, 512, 0,   0, 0);
    tbl[3]  = mk(0, 0, 3'd0, 0, 0, 0, 0, 1, 4, 50,  0,   1, 0);
    tbl[4]  = mk(0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0,   1,   1, 0);
    tbl[5]  = mk(0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0,   2,   1, 0);
    tbl[6]  = mk(0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0,   3,   1, 0);
    tbl[7]  = mk(0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0,   4,   1, 0);
    tbl[8]  = mk(0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0,   5,   1, 0);
    tbl[9]  = mk(0, 1, 3'd0, 0, 0, 0, 0, 0, 0, 0,   5,   0, 1);
    tbl[10] = mk(0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0,   5,   0, 1);
    tbl[11] = mk(1, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0,   0,   0, 0);
    tbl[12] = mk(0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0,   0,   1, 0);
    tbl[13] = mk(0, 0, 3'd2, 2, 1, 0, 1, 0, 0, 0,   1,   1, 0);
    tbl[14] = mk(0, 0, 3'd2, 2, 0, 0, 0, 0, 0, 0,   200, 1, 0);
    tbl[15] = mk(0, 0, 3'd0, 0, 0, 1, 1, 0, 0, 0,   201, 1, 0);
    tbl[16] = mk(0, 0, 3'd4, 7, 0, 0, 0, 0, 0, 0,   512, 1, 0);
    tbl[17] = mk(0, 0, 3'd5, 7, 0, 0, 0, 0, 0, 0,   513, 1, 0);
    tbl[18] = mk(0, 0, 3'd6, 7, 0, 0, 0, 0, 0, 0,   514, 1, 0);
    tbl[19] = mk(0, 0, 3'd7, 7, 0, 0, 0, 0, 0, 0,   515, 1, 0);
    tbl[20] = mk(0, 0, 3'd3, 2, 0, 0, 0, 0, 0, 0,   200, 1, 0);
    tbl[21] = mk(0, 0, 3'd1, 4, 0, 0, 0, 1, 4, 9,   50,  1, 0);
    tbl[22] = mk(0, 0, 3'd1, 4, 0, 0, 0, 0, 0, 0,   9,   1, 0);
    tbl[23] = mk(0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0,   10,  1, 0);
    tbl[24] = mk(1, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0,   0,   0, 0);
    tbl[25] = mk(0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0,   0,   1, 0);
    tbl[26] = mk(0, 0, 3'd2, 2, 0, 0, 0, 0, 0, 0,   1,   1, 0);
    tbl[27] = mk(0, 0, 3'd5, 2, 0, 0, 0, 0, 0, 0,   200, 1, 0);
  end

  // ---------------- main test ----------------
  initial begin
    rst_n = 1'b0;
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    chk_out("reset", 0, 0, 0);
    chk("reset.state", int'(state_dbg), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 28; i++) begin
      set_in(tbl[i].st, tbl[i].ht, tbl[i].cond, tbl[i].idx, tbl[i].zi,
             tbl[i].pi, tbl[i].fwe, tbl[i].lwe, tbl[i].wa, tbl[i].wd);
      step();
      chk_out($sformatf("vec%0d", i), tbl[i].pc, tbl[i].run, tbl[i].dn);
    end

    // Wrap: jump near the top of the address space and step over it
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 5, 1021); step();
    set_in(0, 0, 1, 5, 0, 0, 0, 0, 0, 0);    step();
    chk("wrap.jump", int'(pc_o), 1021);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);    step(); step();
    chk("wrap.top", int'(pc_o), 1023);
    step();
    chk("wrap.zero", int'(pc_o), 0);

    // Restart from RUN at pc 12 with flags set
    set_in(0, 0, 0, 0, 1, 1, 1, 1, 8, 12);   step();
    set_in(0, 0, 1, 8, 0, 0, 0, 0, 0, 0);    step();
    chk("restart.pc12", int'(pc_o), 12);
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);    step();
    chk_out("restart.idle", 0, 0, 0);
    chk("restart.state", int'(state_dbg), 0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);    step();
    set_in(0, 0, 2, 8, 0, 0, 0, 0, 0, 0);    step();
    chk("restart.zero_clr", int'(pc_o), 1);
    set_in(0, 0, 4, 8, 0, 0, 0, 0, 0, 0);    step();
    chk("restart.par_clr", int'(pc_o), 2);

    // HALT then start: done_o falls on the next edge
    set_in(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);    step();
    chk_out("halt", 2, 0, 1);
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);    step();
    chk_out("halt.restart", 0, 0, 0);

    // Run to pc 37, then reset between edges
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 6, 35);   step();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 3, 77);   step();
    set_in(0, 0, 1, 6, 0, 0, 0, 0, 0, 0);    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);    step(); step();
    chk("midrun.pc37", int'(pc_o), 37);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_out("async_rst", 0, 0, 0);
    start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);    step();
    chk_out("post_rst.run", 0, 1, 0);
    set_in(0, 0, 1, 3, 0, 0, 0, 0, 0, 0);    step();
    chk("post_rst.lut3", int'(pc_o), 0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);    step();
    set_in(0, 0, 1, 6, 0, 0, 0, 0, 0, 0);    step();
    chk("post_rst.lut6", int'(pc_o), 0);

    // Random traffic against the model
    for (int n = 0; n < 800; n++) begin
      set_in($urandom_range(0, 29) == 0, $urandom_range(0, 24) == 0,
             3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
             4'($urandom_range(0, 15)), $urandom_range(0, PC_MOD - 1));
      step();
      chk_out($sformatf("rand%0d", n), m_pc, m_mode == "run", m_mode == "halt");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
